popcount_seq: RTL and testbench

Sequential, parametrised set-bit counter with valid/ready handshakes on both input and output. It replaces the single-width go/done bit-counting controller. It clears the lowest set bit once per cycle, so latency scales with the number of set bits rather than with WIDTH. It sits between a producer stream of WIDTH-bit words and a consumer of per-word counts, and supports back-to-back words.

---
 rtl/popcount_pkg.sv | 15 +
 rtl/popcount_seq_if.sv | 38 +++
 rtl/popcount_dp.sv | 51 +++++
 rtl/popcount_seq.sv | 93 +++++++++
 tb/tb_popcount_seq.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared state encoding and count-width helper for popcount_seq
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold any count from 0 to width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/popcount_seq_if.sv
// rtl/popcount_seq_if.sv - word-in / count-out handshake bundle; count_zeros present only with POPCOUNT_SEQ_ZEROS_EN
interface popcount_seq_if
  import popcount_pkg::*;
#(
  parameter int WIDTH = 16
);
  localparam int CW = count_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
`ifdef POPCOUNT_SEQ_ZEROS_EN
  logic             count_zeros;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             busy;

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
`ifdef POPCOUNT_SEQ_ZEROS_EN
    output count_zeros,
`endif
    input  in_ready, out_valid, out_count, busy
  );

  // Counter side.
  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef POPCOUNT_SEQ_ZEROS_EN
    input  count_zeros,
`endif
    output in_ready, out_valid, out_count, busy
  );

endinterface

// File: rtl/popcount_dp.sv
// rtl/popcount_dp.sv - popcount datapath: working word, lowest-set-bit clear, bit counter, result register
module popcount_dp
  import popcount_pkg::*;
#(
  parameter int  WIDTH = 16,
  localparam int CW    = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_step,
  input  logic             i_latch,
  output logic             o_zero,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_num;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_out_count;
  logic [WIDTH-1:0] w_num_clr;

  // Only used while r_num is nonzero, so the decrement never wraps.
  assign w_num_clr = r_num & (r_num - WIDTH'(1));
  assign o_zero    = (r_num == '0);
  assign o_count   = r_out_count;

  // Working word and running count: load a fresh word, or strip one set bit per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_num <= i_data;
      r_cnt <= '0;
    end else if (i_step) begin
      r_num <= w_num_clr;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result register: captured once the word is exhausted, held until the next latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_count <= '0;
    end else if (i_latch) begin
      r_out_count <= r_cnt;
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// rtl/popcount_seq.sv - sequential set-bit counter with handshakes; POPCOUNT_SEQ_ZEROS_EN adds count_zeros
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  popcount_seq_if.slave bus
);

  localparam int CW = count_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_step;
  logic             w_latch;
  logic             w_in_ready;
  logic             w_zero;
  logic [WIDTH-1:0] w_load_data;
  logic [CW-1:0]    w_count;

`ifdef POPCOUNT_SEQ_ZEROS_EN
  assign w_load_data = bus.count_zeros ? ~bus.in_data : bus.in_data;
`else
  assign w_load_data = bus.in_data;
`endif

  popcount_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_step  (w_step),
    .i_latch (w_latch),
    .o_zero  (w_zero),
    .o_count (w_count)
  );

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and datapath enables; DONE hands off straight to the next word when out_ready allows.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_latch    = 1'b0;
    w_in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load = 1'b1;
          w_next = COUNT;
        end
      end
      COUNT: begin
        if (w_zero) begin
          w_latch = 1'b1;
          w_next  = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_load = 1'b1;
            w_next = COUNT;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == COUNT);
  assign bus.out_count = w_count;

endmodule

// File: tb/tb_popcount_seq.sv
// tb/tb_popcount_seq.sv - self-checking bench for popcount_seq; exercises count_zeros when POPCOUNT_SEQ_ZEROS_EN is defined
module tb_popcount_seq;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  popcount_seq_if #(.WIDTH(W)) bus ();

  popcount_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_count !== '0) begin n_fail++; $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Independent words, corners first then random; latency must be popcount+2.
  task automatic test_single_words();
    logic [W-1:0] w;
    logic         cz;
    int           k;
    int           lat;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0:       w = 16'h0000;
        1:       w = 16'hFFFF;
        2:       w = 16'h8000;
        3:       w = 16'h0001;
        default: w = W'($urandom);
      endcase
      cz = 1'b0;
`ifdef POPCOUNT_SEQ_ZEROS_EN
      if (i >= 4) cz = 1'($urandom_range(0, 1));
`endif
      k = cz ? $countones(~w) : $countones(w);
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = w;
`ifdef POPCOUNT_SEQ_ZEROS_EN
      bus.count_zeros = cz;
`endif
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready word=%h got=%b exp=1", w, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = W'($urandom);
`ifdef POPCOUNT_SEQ_ZEROS_EN
      bus.count_zeros = ~cz;
`endif
      lat = 1;
      while (!bus.out_valid && lat < W + 10) begin
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_counting word=%h cycle=%0d got=%b exp=1", w, lat, bus.busy); end
        @(negedge clk);
        lat++;
      end
      n_checks++; if (lat !== k + 2) begin n_fail++; $display("FAIL latency word=%h got=%0d exp=%0d", w, lat, k + 2); end
      n_checks++; if (bus.out_count !== CW'(k)) begin n_fail++; $display("FAIL count word=%h cz=%b got=%0d exp=%0d", w, cz, bus.out_count, k); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_done word=%h got=%b exp=0", w, bus.busy); end
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL back_to_idle word=%h out_valid=%b in_ready=%b exp 0/1", w, bus.out_valid, bus.in_ready); end
    end
`ifdef POPCOUNT_SEQ_ZEROS_EN
    bus.count_zeros = 1'b0;
`endif
  endtask

  // Stream of words offered continuously; each result must follow its handshake by popcount+2 cycles.
  task automatic test_back_to_back();
    logic [W-1:0] words[$];
    int           exp_q[$];
    int           n;
    int           idx;
    int           done;
    int           lat;
    int           cycles;
    int           k;
    logic         hs;
    words.push_back(16'h8001);
    words.push_back(16'h0F0F);
    for (int i = 0; i < 8; i++) words.push_back(W'($urandom));
    n = words.size();
    idx = 0; done = 0; lat = 0; cycles = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = words[0];
    #1 hs = bus.in_valid && bus.in_ready;
    while (done < n && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (hs) begin
        exp_q.push_back($countones(words[idx]));
        idx++;
        lat = 1;
      end else begin
        lat++;
      end
      if (bus.out_valid) begin
        k = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_checks++; if (bus.out_count !== CW'(k)) begin n_fail++; $display("FAIL b2b_count result=%0d got=%0d exp=%0d", done, bus.out_count, k); end
        n_checks++; if (lat !== k + 2) begin n_fail++; $display("FAIL b2b_latency result=%0d got=%0d exp=%0d", done, lat, k + 2); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_done result=%0d got=%b exp=1", done, bus.in_ready); end
        done++;
      end
      if (idx < n) begin
        bus.in_valid = 1'b1;
        bus.in_data  = words[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1 hs = bus.in_valid && bus.in_ready;
    end
    n_checks++; if (done !== n) begin n_fail++; $display("FAIL b2b_results_seen got=%0d exp=%0d", done, n); end
    bus.in_valid = 1'b0;
  endtask

  // Result held under back-pressure; a waiting word is only taken once out_ready returns.
  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h00A5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < W + 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL bp_latency got=%0d exp=6", lat); end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cycle=%0d got=%b exp=1", i, bus.out_valid); end
      n_checks++; if (bus.out_count !== CW'(4)) begin n_fail++; $display("FAIL bp_hold_count cycle=%0d got=%0d exp=4", i, bus.out_count); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", i, bus.in_ready); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handoff busy=%b out_valid=%b exp 1/0", bus.busy, bus.out_valid); end
    lat = 1;
    while (!bus.out_valid && lat < W + 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL bp_second_latency got=%0d exp=10", lat); end
    n_checks++; if (bus.out_count !== CW'(8)) begin n_fail++; $display("FAIL bp_second_count got=%0d exp=8", bus.out_count); end
    @(negedge clk);
  endtask

  // Asynchronous reset during counting drops the word; the next word counts normally.
  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h00FF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_count !== '0) begin n_fail++; $display("FAIL rst_mid_out_count got=%0d exp=0", bus.out_count); end
    n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle busy=%b in_ready=%b exp 0/1", bus.busy, bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_partial out_valid=%b busy=%b exp 0/0", bus.out_valid, bus.busy); end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0003;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < W + 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rst_mid_next_latency got=%0d exp=4", lat); end
    n_checks++; if (bus.out_count !== CW'(2)) begin n_fail++; $display("FAIL rst_mid_next_count got=%0d exp=2", bus.out_count); end
    @(negedge clk);
  endtask

`ifdef POPCOUNT_SEQ_ZEROS_EN
  // Zero counting: 16'h00F0 has 12 zero bits.
  task automatic test_zeros();
    int lat;
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = 16'h00F0;
    bus.count_zeros = 1'b1;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.count_zeros = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < W + 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL zeros_latency got=%0d exp=14", lat); end
    n_checks++; if (bus.out_count !== CW'(12)) begin n_fail++; $display("FAIL zeros_count got=%0d exp=12", bus.out_count); end
    @(negedge clk);
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef POPCOUNT_SEQ_ZEROS_EN
    bus.count_zeros = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_single_words();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef POPCOUNT_SEQ_ZEROS_EN
    test_zeros();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
